// File: rtl/int_exec_pipe_pkg.sv
// Shared types for the integer execute pipe: opcodes, issue and CDB payloads,
// ALU operation enum and the opcode/func decoder.
package int_exec_pipe_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned TagW  = 6;

  localparam logic [6:0] R_TYPE      = 7'b0110011;
  localparam logic [6:0] I_TYPE      = 7'b0010011;
  localparam logic [6:0] LUI_TYPE    = 7'b0110111;
  localparam logic [6:0] BRANCH_TYPE = 7'b1100011;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic [DataW-1:0] rs1_data;
    logic [DataW-1:0] rs2_data;  // immediate for I-type and LUI
    logic [TagW-1:0]  rd_tag;
  } int_fifo_data;

  typedef struct packed {
    logic             cdb_valid;
    logic [TagW-1:0]  cdb_tag;
    logic [DataW-1:0] cdb_result;
    logic             cdb_branch;
    logic             cdb_branch_taken;
  } cdb_bfm;

  typedef enum logic [3:0] {
    AluZero, AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor,
    AluSrl, AluSra, AluOr, AluAnd, AluPass, AluBranch
  } alu_op_e;

  // Undefined func3/func7 combinations and unknown opcodes map to AluZero.
  function automatic alu_op_e decode_op(input logic [6:0] opcode, input logic [2:0] func3,
                                        input logic [6:0] func7);
    alu_op_e op;
    op = AluZero;
    case (opcode)
      R_TYPE: begin
        case (func3)
          3'b000: op = (func7 == 7'h00) ? AluAdd : (func7 == 7'h20) ? AluSub : AluZero;
          3'b001: op = (func7 == 7'h00) ? AluSll : AluZero;
          3'b010: op = (func7 == 7'h00) ? AluSlt : AluZero;
          3'b011: op = (func7 == 7'h00) ? AluSltu : AluZero;
          3'b100: op = (func7 == 7'h00) ? AluXor : AluZero;
          3'b101: op = (func7 == 7'h00) ? AluSrl : (func7 == 7'h20) ? AluSra : AluZero;
          3'b110: op = (func7 == 7'h00) ? AluOr : AluZero;
          3'b111: op = (func7 == 7'h00) ? AluAnd : AluZero;
        endcase
      end
      I_TYPE: begin
        case (func3)
          3'b000: op = AluAdd;
          3'b001: op = AluSll;
          3'b010: op = AluSlt;
          3'b011: op = AluSltu;
          3'b100: op = AluXor;
          3'b101: op = func7[5] ? AluSra : AluSrl;
          3'b110: op = AluOr;
          3'b111: op = AluAnd;
        endcase
      end
      LUI_TYPE:    op = AluPass;
      BRANCH_TYPE: op = AluBranch;
      default:     op = AluZero;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cdb_out_fifo.sv
// Result buffer between the execute pipeline and the CDB; power-of-two depth FIFO
// with synchronous reset and a synchronous clear.
module cdb_out_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CntW'(Depth));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign o_data    = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PtrW'(1);
      r_count <= r_count + CntW'(w_do_push) - CntW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/int_exec_pipe.sv
// Integer execute unit: decode + ALU on the accepted op, LATENCY-deep result path
// into a credit-controlled CDB result buffer.
module int_exec_pipe
  import int_exec_pipe_pkg::*;
#(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned OUT_DEPTH = 2,
  parameter int unsigned XLEN      = 32  // must equal DataW of the package
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         issue_valid,
  output logic         issue_ready,
  input  int_fifo_data issue_data,
  input  logic         flush,
  output logic         cdb_req,
  input  logic         cdb_grant,
  output cdb_bfm       o_int_submit,
  output logic         busy
);

  localparam int unsigned ShW  = $clog2(XLEN);
  localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);

  logic             w_accept;
  logic             w_pop;
  alu_op_e          w_op;
  logic [DataW-1:0] w_rs1;
  logic [DataW-1:0] w_rs2;
  logic [ShW-1:0]   w_shamt;
  logic [DataW-1:0] w_result;
  logic             w_taken;
  cdb_bfm           w_bfm;
  logic [CntW-1:0]  r_cnt;
  logic [CntW-1:0]  w_cnt_next;
  logic             w_empty;
  logic [$bits(cdb_bfm)-1:0] w_head;

  assign w_accept = issue_valid & issue_ready & ~flush;
  assign w_rs1    = issue_data.rs1_data;
  assign w_rs2    = issue_data.rs2_data;
  assign w_shamt  = w_rs2[ShW-1:0];
  assign w_op     = decode_op(issue_data.opcode, issue_data.func3, issue_data.func7);

  always_comb begin
    w_result = '0;
    case (w_op)
      AluAdd:  w_result = w_rs1 + w_rs2;
      AluSub:  w_result = w_rs1 - w_rs2;
      AluSll:  w_result = w_rs1 << w_shamt;
      AluSlt:  w_result = {{(DataW-1){1'b0}}, $signed(w_rs1) < $signed(w_rs2)};
      AluSltu: w_result = {{(DataW-1){1'b0}}, w_rs1 < w_rs2};
      AluXor:  w_result = w_rs1 ^ w_rs2;
      AluSrl:  w_result = w_rs1 >> w_shamt;
      AluSra:  w_result = $unsigned($signed(w_rs1) >>> w_shamt);
      AluOr:   w_result = w_rs1 | w_rs2;
      AluAnd:  w_result = w_rs1 & w_rs2;
      AluPass: w_result = w_rs2;
      default: w_result = '0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (issue_data.func3)
      3'b000:  w_taken = (w_rs1 == w_rs2);
      3'b001:  w_taken = (w_rs1 != w_rs2);
      3'b100:  w_taken = ($signed(w_rs1) < $signed(w_rs2));
      3'b101:  w_taken = ($signed(w_rs1) >= $signed(w_rs2));
      3'b110:  w_taken = (w_rs1 < w_rs2);
      3'b111:  w_taken = (w_rs1 >= w_rs2);
      default: w_taken = 1'b0;
    endcase
  end

  // Branch entries carry only the outcome; tag and result are forced to zero.
  always_comb begin
    w_bfm = '0;
    if (w_op == AluBranch) begin
      w_bfm.cdb_branch       = 1'b1;
      w_bfm.cdb_branch_taken = w_taken;
    end else begin
      w_bfm.cdb_valid  = 1'b1;
      w_bfm.cdb_tag    = issue_data.rd_tag;
      w_bfm.cdb_result = w_result;
    end
  end

  // Stage 0 is the combinational ALU; the buffer write is the final registered stage,
  // so LATENCY-1 flop stages sit between them.
  logic   w_stg_vld [LATENCY];
  cdb_bfm w_stg_bfm [LATENCY];

  assign w_stg_vld[0] = w_accept;
  assign w_stg_bfm[0] = w_bfm;

  for (genvar i = 1; i < LATENCY; i++) begin : g_stage
    logic   r_vld;
    cdb_bfm r_bfm;
    always_ff @(posedge clk) begin
      if (rst || flush) r_vld <= 1'b0;
      else              r_vld <= w_stg_vld[i-1];
      r_bfm <= w_stg_bfm[i-1];
    end
    assign w_stg_vld[i] = r_vld;
    assign w_stg_bfm[i] = r_bfm;
  end

  assign cdb_req = ~w_empty;
  assign w_pop   = cdb_req & cdb_grant;

  cdb_out_fifo #(
    .Width ($bits(cdb_bfm)),
    .Depth (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (flush),
    .i_push  (w_stg_vld[LATENCY-1]),
    .i_data  (w_stg_bfm[LATENCY-1]),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty)
  );

  assign o_int_submit = cdb_req ? cdb_bfm'(w_head) : '0;

  // Credits cover in-flight plus buffered ops; ready comes only from the register.
  assign w_cnt_next = r_cnt + CntW'(w_accept) - CntW'(w_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) r_cnt <= '0;
    else              r_cnt <= w_cnt_next;
  end

  assign issue_ready = (r_cnt < CntW'(OUT_DEPTH));
  assign busy        = (r_cnt != '0);

endmodule

// File: tb/tb_int_exec_pipe.sv
// Directed self-checking bench for int_exec_pipe at LATENCY=2, OUT_DEPTH=2.
module tb_int_exec_pipe;
  import int_exec_pipe_pkg::*;

  localparam int Lat = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue_valid;
  logic         issue_ready;
  int_fifo_data issue_data;
  logic         flush;
  logic         cdb_req;
  logic         cdb_grant;
  cdb_bfm       o_int_submit;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  int_exec_pipe #(
    .LATENCY   (Lat),
    .OUT_DEPTH (2),
    .XLEN      (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_data   (issue_data),
    .flush        (flush),
    .cdb_req      (cdb_req),
    .cdb_grant    (cdb_grant),
    .o_int_submit (o_int_submit),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic cdb_bfm mk(input logic v, input logic [TagW-1:0] t,
                                input logic [DataW-1:0] r, input logic b, input logic tk);
    cdb_bfm e;
    e.cdb_valid        = v;
    e.cdb_tag          = t;
    e.cdb_result       = r;
    e.cdb_branch       = b;
    e.cdb_branch_taken = tk;
    return e;
  endfunction

  function automatic int_fifo_data op(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [31:0] a,
                                      input logic [31:0] b, input logic [TagW-1:0] t);
    int_fifo_data d;
    d.opcode   = opc;
    d.func3    = f3;
    d.func7    = f7;
    d.rs1_data = a;
    d.rs2_data = b;
    d.rd_tag   = t;
    return d;
  endfunction

  // Issue one op with grant held high, measure latency to cdb_req, check the entry.
  task automatic run_one(input string name, input int_fifo_data d, input cdb_bfm exp);
    int lat;
    check_eq({name, "_ready"}, 64'(issue_ready), 64'd1);
    issue_valid = 1'b1;
    issue_data  = d;
    cdb_grant   = 1'b1;
    tick();
    issue_valid = 1'b0;
    issue_data  = '0;
    lat = 1;
    while (!cdb_req && lat < 10) begin
      tick();
      lat++;
    end
    check_eq({name, "_lat"}, 64'(lat), 64'(Lat));
    check_eq(name, 64'(o_int_submit), 64'(exp));
    tick();
  endtask

  task automatic check_idle(input string name);
    check_eq({name, "_req"}, 64'(cdb_req), 64'd0);
    check_eq({name, "_busy"}, 64'(busy), 64'd0);
    check_eq({name, "_ready"}, 64'(issue_ready), 64'd1);
    check_eq({name, "_submit"}, 64'(o_int_submit), 64'd0);
  endtask

  initial begin
    int seen;
    rst         = 1'b1;
    issue_valid = 1'b0;
    issue_data  = '0;
    flush       = 1'b0;
    cdb_grant   = 1'b1;  // grant while empty must be ignored
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    tick();
    check_idle("reset_grant_idle");

    // ALU and branch vectors
    run_one("add",      op(R_TYPE, 3'd0, 7'h00, 32'd5, 32'd7, 6'd3),
            mk(1'b1, 6'd3, 32'd12, 1'b0, 1'b0));
    run_one("sub",      op(R_TYPE, 3'd0, 7'h20, 32'd5, 32'd7, 6'd4),
            mk(1'b1, 6'd4, 32'hFFFF_FFFE, 1'b0, 1'b0));
    run_one("sra",      op(R_TYPE, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 6'd5),
            mk(1'b1, 6'd5, 32'hF800_0000, 1'b0, 1'b0));
    run_one("srl",      op(R_TYPE, 3'd5, 7'h00, 32'h8000_0000, 32'd4, 6'd6),
            mk(1'b1, 6'd6, 32'h0800_0000, 1'b0, 1'b0));
    run_one("slt",      op(R_TYPE, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 6'd7),
            mk(1'b1, 6'd7, 32'd1, 1'b0, 1'b0));
    run_one("sltu",     op(R_TYPE, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 6'd8),
            mk(1'b1, 6'd8, 32'd0, 1'b0, 1'b0));
    run_one("xor",      op(R_TYPE, 3'd4, 7'h00, 32'h0000_F0F0, 32'h0000_FF00, 6'd9),
            mk(1'b1, 6'd9, 32'h0000_0FF0, 1'b0, 1'b0));
    run_one("sll_mask", op(R_TYPE, 3'd1, 7'h00, 32'd1, 32'h21, 6'd10),
            mk(1'b1, 6'd10, 32'd2, 1'b0, 1'b0));
    run_one("and",      op(R_TYPE, 3'd7, 7'h00, 32'hFF00_FF00, 32'h0FF0_0FF0, 6'd11),
            mk(1'b1, 6'd11, 32'h0F00_0F00, 1'b0, 1'b0));
    run_one("or",       op(R_TYPE, 3'd6, 7'h00, 32'h0000_00F0, 32'h0000_000F, 6'd12),
            mk(1'b1, 6'd12, 32'h0000_00FF, 1'b0, 1'b0));
    run_one("r_undef0", op(R_TYPE, 3'd0, 7'h01, 32'd9, 32'd9, 6'd13),
            mk(1'b1, 6'd13, 32'd0, 1'b0, 1'b0));
    run_one("r_undef1", op(R_TYPE, 3'd1, 7'h20, 32'd9, 32'd1, 6'd14),
            mk(1'b1, 6'd14, 32'd0, 1'b0, 1'b0));
    run_one("addi",     op(I_TYPE, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'd1, 6'd15),
            mk(1'b1, 6'd15, 32'd0, 1'b0, 1'b0));
    run_one("slti",     op(I_TYPE, 3'd2, 7'h00, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 6'd16),
            mk(1'b1, 6'd16, 32'd1, 1'b0, 1'b0));
    run_one("srai",     op(I_TYPE, 3'd5, 7'h20, 32'h8000_0000, 32'd1, 6'd17),
            mk(1'b1, 6'd17, 32'hC000_0000, 1'b0, 1'b0));
    run_one("slli",     op(I_TYPE, 3'd1, 7'h00, 32'd3, 32'd31, 6'd18),
            mk(1'b1, 6'd18, 32'h8000_0000, 1'b0, 1'b0));
    run_one("lui",      op(LUI_TYPE, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'h1234_5000, 6'd19),
            mk(1'b1, 6'd19, 32'h1234_5000, 1'b0, 1'b0));
    run_one("unk_opc",  op(7'b0000011, 3'd0, 7'h00, 32'd4, 32'd4, 6'd20),
            mk(1'b1, 6'd20, 32'd0, 1'b0, 1'b0));
    run_one("bge",      op(BRANCH_TYPE, 3'd5, 7'h00, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 6'd21),
            mk(1'b0, 6'd0, 32'd0, 1'b1, 1'b1));
    run_one("bltu",     op(BRANCH_TYPE, 3'd6, 7'h00, 32'd1, 32'd0, 6'd22),
            mk(1'b0, 6'd0, 32'd0, 1'b1, 1'b0));
    run_one("beq",      op(BRANCH_TYPE, 3'd0, 7'h00, 32'd3, 32'd3, 6'd23),
            mk(1'b0, 6'd0, 32'd0, 1'b1, 1'b1));
    run_one("bne",      op(BRANCH_TYPE, 3'd1, 7'h00, 32'd3, 32'd3, 6'd24),
            mk(1'b0, 6'd0, 32'd0, 1'b1, 1'b0));
    run_one("blt",      op(BRANCH_TYPE, 3'd4, 7'h00, 32'hFFFF_FFFF, 32'd0, 6'd25),
            mk(1'b0, 6'd0, 32'd0, 1'b1, 1'b1));
    run_one("bgeu",     op(BRANCH_TYPE, 3'd7, 7'h00, 32'd0, 32'hFFFF_FFFF, 6'd26),
            mk(1'b0, 6'd0, 32'd0, 1'b1, 1'b0));
    run_one("b_undef",  op(BRANCH_TYPE, 3'd2, 7'h00, 32'd5, 32'd5, 6'd27),
            mk(1'b0, 6'd0, 32'd0, 1'b1, 1'b0));

    // Backpressure: two credits, held op stays untouched, freed credit, order kept
    cdb_grant   = 1'b0;
    issue_valid = 1'b1;
    issue_data  = op(R_TYPE, 3'd0, 7'h00, 32'd1, 32'd1, 6'd1);
    check_eq("bp_ready0", 64'(issue_ready), 64'd1);
    tick();
    issue_data = op(R_TYPE, 3'd0, 7'h00, 32'd2, 32'd2, 6'd2);
    check_eq("bp_ready1", 64'(issue_ready), 64'd1);
    tick();
    issue_data = op(R_TYPE, 3'd0, 7'h00, 32'd3, 32'd3, 6'd3);
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_stall", 64'(issue_ready), 64'd0);
      tick();
    end
    check_eq("bp_req", 64'(cdb_req), 64'd1);
    check_eq("bp_head_a", 64'(o_int_submit), 64'(mk(1'b1, 6'd1, 32'd2, 1'b0, 1'b0)));
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    check_eq("bp_freed", 64'(issue_ready), 64'd1);
    check_eq("bp_head_b", 64'(o_int_submit), 64'(mk(1'b1, 6'd2, 32'd4, 1'b0, 1'b0)));
    tick();
    issue_valid = 1'b0;
    issue_data  = '0;
    check_eq("bp_full_again", 64'(issue_ready), 64'd0);
    cdb_grant = 1'b1;
    check_eq("bp_head_b_hold", 64'(o_int_submit), 64'(mk(1'b1, 6'd2, 32'd4, 1'b0, 1'b0)));
    tick();
    check_eq("bp_head_c", 64'(o_int_submit), 64'(mk(1'b1, 6'd3, 32'd6, 1'b0, 1'b0)));
    tick();
    cdb_grant = 1'b0;
    check_idle("bp_drained");

    // Flush with one buffered and one in flight
    issue_valid = 1'b1;
    issue_data  = op(R_TYPE, 3'd0, 7'h00, 32'd10, 32'd1, 6'd5);
    tick();
    issue_data = op(R_TYPE, 3'd0, 7'h00, 32'd20, 32'd1, 6'd6);
    tick();
    issue_valid = 1'b0;
    issue_data  = '0;
    check_eq("fl_req_before", 64'(cdb_req), 64'd1);
    check_eq("fl_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_idle("fl_after");
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (cdb_req) seen++;
      tick();
    end
    check_eq("fl_no_stale", 64'(seen), 64'd0);
    run_one("fl_next", op(R_TYPE, 3'd0, 7'h00, 32'd40, 32'd2, 6'd9),
            mk(1'b1, 6'd9, 32'd42, 1'b0, 1'b0));

    // Reset mid-stream, with flush also asserted
    cdb_grant   = 1'b0;
    issue_valid = 1'b1;
    issue_data  = op(R_TYPE, 3'd0, 7'h00, 32'd7, 32'd7, 6'd30);
    tick();
    issue_data = op(R_TYPE, 3'd0, 7'h00, 32'd8, 32'd8, 6'd31);
    tick();
    issue_valid = 1'b0;
    issue_data  = '0;
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    check_idle("rst_after");
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (cdb_req) seen++;
      tick();
    end
    check_eq("rst_no_stale", 64'(seen), 64'd0);
    run_one("rst_next", op(I_TYPE, 3'd4, 7'h00, 32'h0000_00FF, 32'h0000_000F, 6'd2),
            mk(1'b1, 6'd2, 32'h0000_00F0, 1'b0, 1'b0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
